// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and helpers for the AES block-chaining controller
package aes_pkg;

   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      MODE_ECB = 2'd0,
      MODE_CBC = 2'd1,
      MODE_CTR = 2'd2
   } aes_mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_IN = 2'd1,
      RUN     = 2'd2,
      GAP     = 2'd3
   } aes_state_e;

   // Bumps only the low ctr_w bits so the counter wraps without carrying into the nonce.
   function automatic aes_block_t ctr_inc(input aes_block_t blk, input int ctr_w);
      aes_block_t mask;
      mask = (ctr_w >= 128) ? '1 : ((aes_block_t'(1) << ctr_w) - aes_block_t'(1));
      return (blk & ~mask) | ((blk + aes_block_t'(1)) & mask);
   endfunction

endpackage

// File: rtl/aes_out_fifo.sv
// rtl/aes_out_fifo.sv - output FIFO holding ciphertext blocks with their last flags
module aes_out_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 129,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_pop;
   logic             do_push;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A pop frees the slot a simultaneous push needs, so full-with-pop still writes.
   assign do_pop    = pop && (count != '0);
   assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/aes_mode_ctrl.sv
// rtl/aes_mode_ctrl.sv - ECB/CBC/CTR chaining controller in front of a single-block AES core
module aes_mode_ctrl
   import aes_pkg::*;
#(
   parameter int OUT_DEPTH = 4,
   parameter int CTR_W     = 32
) (
   input  logic         AES_clk,
   input  logic         AES_rst_n,
   input  logic         cfg_load,
   input  logic [1:0]   cfg_mode,
   input  logic [127:0] cfg_key,
   input  logic [127:0] cfg_iv,
   input  logic         abort,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_last,
   output logic         busy,
   output logic         core_en,
   output logic [127:0] core_data_in,
   output logic [127:0] core_key_in,
   input  logic [127:0] core_data_out,
   input  logic         core_data_out_valid
);

   localparam int CNT_W = $clog2(OUT_DEPTH + 1);

   aes_state_e       state_q;
   aes_state_e       state_d;
   aes_mode_e        mode_q;
   aes_block_t       key_q;
   aes_block_t       chain_q;
   aes_block_t       ctr_q;
   aes_block_t       data_q;
   aes_block_t       core_in_q;
   aes_block_t       result;
   logic             last_q;
   logic             in_ready_q;
   logic             load;
   logic             accept;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] count_next;
   logic [128:0]     fifo_head;

   assign load   = (state_q == IDLE) && cfg_load && !abort;
   assign accept = in_valid && in_ready_q && !abort;
   assign push   = (state_q == RUN) && core_data_out_valid && !abort;
   assign pop    = out_valid && out_ready;
   assign result = (mode_q == MODE_CTR) ? (core_data_out ^ data_q) : core_data_out;

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (cfg_load) state_d = WAIT_IN;
            WAIT_IN: if (accept) state_d = RUN;
            RUN:     if (core_data_out_valid) state_d = GAP;
            GAP:     state_d = last_q ? IDLE : WAIT_IN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Occupancy one cycle ahead keeps in_ready registered yet reactive to pops.
   assign count_next = abort ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         mode_q     <= MODE_ECB;
         key_q      <= '0;
         chain_q    <= '0;
         ctr_q      <= '0;
         data_q     <= '0;
         core_in_q  <= '0;
         last_q     <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= (state_d == WAIT_IN) && (count_next < CNT_W'(OUT_DEPTH));
         if (load) begin
            mode_q  <= (cfg_mode == 2'd3) ? MODE_ECB : aes_mode_e'(cfg_mode);
            key_q   <= cfg_key;
            chain_q <= cfg_iv;
            ctr_q   <= cfg_iv;
         end
         if (accept) begin
            data_q <= in_data;
            last_q <= in_last;
            case (mode_q)
               MODE_CBC: core_in_q <= in_data ^ chain_q;
               MODE_CTR: core_in_q <= ctr_q;
               default:  core_in_q <= in_data;
            endcase
         end
         if (push) begin
            if (mode_q == MODE_CBC) chain_q <= result;
            if (mode_q == MODE_CTR) ctr_q <= ctr_inc(ctr_q, CTR_W);
         end
      end
   end

   aes_out_fifo #(
      .DEPTH (OUT_DEPTH),
      .WIDTH (129),
      .CNT_W (CNT_W)
   ) u_out_fifo (
      .clk       (AES_clk),
      .rst_n     (AES_rst_n),
      .flush     (abort),
      .push      (push),
      .push_data ({last_q, result}),
      .pop       (pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   assign in_ready     = in_ready_q;
   assign out_valid    = (fifo_count != '0);
   assign out_data     = fifo_head[127:0];
   assign out_last     = fifo_head[128];
   assign busy         = (state_q != IDLE);
   assign core_en      = (state_q == RUN);
   assign core_data_in = core_in_q;
   assign core_key_in  = key_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb/tb_aes_mode_ctrl.sv - scoreboard bench for aes_mode_ctrl with a 10-cycle behavioural AES core
module tb_aes_mode_ctrl;

   localparam logic [127:0] K1      = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P1      = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] P2      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] CBC1    = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] CBC2    = 128'h5086cb9b507219ee95db113a917678b2;
   localparam logic [127:0] CTR0    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] CTR1    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
   localparam logic [127:0] CTR_CT1 = 128'h874d6191b620e3261bef6864990db6ce;
   localparam logic [127:0] IVW     = 128'h00112233445566778899aabbffffffff;
   localparam logic [127:0] WRAP2   = 128'h00112233445566778899aabb00000000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_load = 1'b0;
   logic [1:0]   cfg_mode = '0;
   logic [127:0] cfg_key = '0;
   logic [127:0] cfg_iv = '0;
   logic         abort = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         out_last;
   logic         busy;
   logic         core_en;
   logic [127:0] core_data_in;
   logic [127:0] core_key_in;
   logic [127:0] core_data_out;
   logic         core_data_out_valid;

   int           checks = 0;
   int           errors = 0;
   int           core_starts = 0;
   logic [128:0] exp_out_q[$];
   logic [127:0] exp_core_q[$];
   logic [127:0] exp_key = '0;
   logic [7:0]   sbox[256];

   always #5 clk = ~clk;

   aes_mode_ctrl #(.OUT_DEPTH(4), .CTR_W(32)) dut (
      .AES_clk             (clk),
      .AES_rst_n           (rst_n),
      .cfg_load            (cfg_load),
      .cfg_mode            (cfg_mode),
      .cfg_key             (cfg_key),
      .cfg_iv              (cfg_iv),
      .abort               (abort),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_data             (in_data),
      .in_last             (in_last),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_data            (out_data),
      .out_last            (out_last),
      .busy                (busy),
      .core_en             (core_en),
      .core_data_in        (core_data_in),
      .core_key_in         (core_key_in),
      .core_data_out       (core_data_out),
      .core_data_out_valid (core_data_out_valid)
   );

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   initial begin
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = '0;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   end

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w[44];
      logic [7:0]   st[16];
      logic [7:0]   tmp[16];
      logic [7:0]   rc;
      logic [31:0]  t;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
         for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++) tmp[rr+4*c] = st[rr+4*((c+rr)%4)];
         for (int i = 0; i < 16; i++) st[i] = tmp[i];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   // Behavioural core: restarts on each rising core_en, answers 10 cycles later.
   logic         en_d;
   int           core_cnt;
   logic [127:0] core_res;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_d                <= 1'b0;
         core_cnt            <= 0;
         core_res            <= '0;
         core_data_out       <= '0;
         core_data_out_valid <= 1'b0;
      end else begin
         en_d                <= core_en;
         core_data_out_valid <= 1'b0;
         if (core_en && !en_d) begin
            core_res <= aes_ref(core_key_in, core_data_in);
            core_cnt <= 10;
         end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
               core_data_out_valid <= 1'b1;
               core_data_out       <= core_res;
            end
         end
      end
   end

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   logic en_seen = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_out_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_unexpected: got %h required no output", {out_last, out_data});
            end else begin
               check("out_block", {out_last, out_data}, exp_out_q.pop_front());
            end
         end
         if (core_en && !en_seen) begin
            core_starts++;
            if (exp_core_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL core_unexpected: got %h required no core start", core_data_in);
            end else begin
               check("core_in", 129'(core_data_in), 129'(exp_core_q.pop_front()));
            end
            check("core_key", 129'(core_key_in), 129'(exp_key));
         end
      end
      en_seen <= core_en;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] mode, input logic [127:0] key, input logic [127:0] iv);
      cfg_mode = mode;
      cfg_key  = key;
      cfg_iv   = iv;
      cfg_load = 1'b1;
      exp_key  = key;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic send(input logic [127:0] d, input logic l, input logic [127:0] eo,
                       input logic [127:0] ec);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 500) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 required 1 within 500 cycles");
         in_valid = 1'b0;
         return;
      end
      exp_out_q.push_back({l, eo});
      exp_core_q.push_back(ec);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((busy || exp_out_q.size() != 0) && n < 1000) begin
         tick();
         n++;
      end
      check(name, 129'(busy || exp_out_q.size() != 0), 129'(0));
   endtask

   initial begin
      int            base;
      logic          stuck;
      logic [127:0]  bp;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 129'({in_ready, out_valid, out_last, busy, core_en}), 129'(0));
      check("reset_out_data", 129'(out_data), 129'(0));
      check("reset_core_bus", 129'(core_data_in | core_key_in), 129'(0));
      rst_n = 1'b1;
      tick();

      // ECB known-answer vector
      cfg(2'd0, K1, '0);
      check("cfg_busy", 129'(busy), 129'(1));
      send(PT_C1, 1'b1, CT_C1, PT_C1);
      wait_drain("ecb_drain");
      check("ecb_busy_fall", 129'(busy), 129'(0));

      // CBC two-block chain
      cfg(2'd1, K2, K1);
      send(P1, 1'b0, CBC1, P1 ^ K1);
      send(P2, 1'b1, CBC2, P2 ^ CBC1);
      wait_drain("cbc_drain");

      // CTR with counter increment
      cfg(2'd2, K2, CTR0);
      send(P1, 1'b0, CTR_CT1, CTR0);
      send(P2, 1'b1, aes_ref(K2, CTR1) ^ P2, CTR1);
      wait_drain("ctr_drain");

      // CTR low-field wrap leaves the upper 96 bits alone
      cfg(2'd2, K1, IVW);
      send(P2, 1'b0, aes_ref(K1, IVW) ^ P2, IVW);
      send(P1, 1'b1, aes_ref(K1, WRAP2) ^ P1, WRAP2);
      wait_drain("wrap_drain");

      // Backpressure: FIFO fills at four blocks
      out_ready = 1'b0;
      base = core_starts;
      cfg(2'd0, K1, '0);
      bp = PT_C1;
      for (int i = 0; i < 4; i++) begin
         bp[7:0] = 8'(i);
         send(bp, 1'b0, aes_ref(K1, bp), bp);
      end
      repeat (30) tick();
      check("bp_in_ready_full", 129'(in_ready), 129'(0));
      check("bp_out_valid", 129'(out_valid), 129'(1));
      check("bp_accepted", 129'(core_starts - base), 129'(4));
      bp[7:0] = 8'd4;
      in_valid = 1'b1;
      in_data  = bp;
      stuck    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         stuck = stuck | in_ready;
         tick();
      end
      in_valid = 1'b0;
      check("bp_no_accept", 129'(stuck), 129'(0));
      out_ready = 1'b1;
      send(bp, 1'b0, aes_ref(K1, bp), bp);
      bp[7:0] = 8'd5;
      send(bp, 1'b1, aes_ref(K1, bp), bp);
      wait_drain("bp_drain");

      // Abort mid-RUN with two entries queued
      out_ready = 1'b0;
      cfg(2'd0, K1, '0);
      send(P1, 1'b0, aes_ref(K1, P1), P1);
      send(P2, 1'b0, aes_ref(K1, P2), P2);
      send(PT_C1, 1'b0, CT_C1, PT_C1);
      repeat (2) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_state", 129'({out_valid, core_en, busy}), 129'(0));
      exp_out_q.delete();
      out_ready = 1'b1;
      repeat (20) tick();
      check("abort_discard", 129'({out_valid, busy}), 129'(0));
      cfg(2'd0, K1, '0);
      send(PT_C1, 1'b1, CT_C1, PT_C1);
      wait_drain("post_abort_drain");

      // Reserved mode falls back to ECB
      cfg(2'd3, K1, K2);
      send(PT_C1, 1'b1, CT_C1, PT_C1);
      wait_drain("mode3_drain");

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion required finish before 500000 ns");
      $fatal(1);
   end

endmodule

// File: doc/aes_mode_ctrl.md
# aes_mode_ctrl

Block-chaining controller between a 128-bit streaming interface and one iterative `AES_top` core instance. It adds ECB, CBC-encrypt and CTR modes, multi-block messages, ready/valid flow control and a parametrised output buffer. The core itself only provides single-block ECB. The block sits directly above `AES_top` in the datapath hierarchy. It owns the core's `AES_en`, `AES_data_in` and `AES_key_in` inputs.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- `OUT_DEPTH`, default 4: output FIFO entries, must be ≥ 2.
- `CTR_W`, default 32: width of the CTR counter field, taken from the low bits of the IV, range 8..128.

Ports:
- `AES_clk` in 1: clock.
- `AES_rst_n` in 1: async active-low reset.
- `cfg_load` in 1: start-of-message strobe, sampled only in `IDLE`.
- `cfg_mode` in 2: 0 ECB, 1 CBC-encrypt, 2 CTR, 3 reserved (treated as ECB).
- `cfg_key` in 128: key, latched on an accepted `cfg_load`.
- `cfg_iv` in 128: CBC IV or CTR initial counter block, latched on an accepted `cfg_load`.
- `abort` in 1: synchronous flush.
- `in_valid` / `in_ready` in / out 1: input handshake.
- `in_data` in 128: plaintext block.
- `in_last` in 1: last block of the message.
- `out_valid` / `out_ready` out / in 1: output handshake.
- `out_data` out 128: ciphertext block.
- `out_last` out 1: last ciphertext block of the message.
- `busy` out 1: high in any state other than `IDLE`.
- `core_en` out 1: drives `AES_en`.
- `core_data_in` out 128: drives `AES_data_in`.
- `core_key_in` out 128: drives `AES_key_in`.
- `core_data_out` in 128: from `AES_data_out`.
- `core_data_out_valid` in 1: from `AES_data_out_valid`.

## Operation
States and transitions:
- `IDLE`: `cfg_load` latches mode, key and IV into registers, then goes to `WAIT_IN`.
- `WAIT_IN`: `in_ready` = 1 iff FIFO occupancy < `OUT_DEPTH`. A transfer (`in_valid && in_ready`) latches `in_data` and `in_last`, computes the core input, then goes to `RUN`.
- `RUN`: `core_en` = 1, and `core_data_in` / `core_key_in` are held stable. In the cycle `core_data_out_valid` = 1, the result is post-processed and pushed to the FIFO with the latched last flag. Next state is `GAP`.
- `GAP`: one cycle with `core_en` = 0, guaranteeing the core sees a falling edge between blocks. Goes to `IDLE` if the block was last, otherwise `WAIT_IN`.

Per-mode core input and result:
- ECB: core input = `in_data`; result = core output.
- CBC: core input = `in_data ^ chain`; result = core output. The chain register is loaded with the IV at `cfg_load` and updated to the result on each push.
- CTR: core input = counter block; result = core output `^` latched `in_data`. On each push the low `CTR_W` bits of the counter block increment modulo 2^`CTR_W`; the upper 128−`CTR_W` bits never change, so the counter wraps with no carry into them.

Other rules:
- The FIFO reservation happens at input acceptance. Only one block is in flight, so a push never meets a full FIFO.
- FIFO: `out_valid` = not empty. `out_data` and `out_last` present the head entry. A pop occurs on `out_valid && out_ready`. A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- `abort` has priority over every other event: go to `IDLE`, empty the FIFO, drop `core_en` the next cycle, and discard any core result still pending. Key, IV and chain registers keep their values but are reloaded by the next `cfg_load`.
- `cfg_load` outside `IDLE` is ignored.

## Timing
- Reset values: state `IDLE`; `in_ready`, `out_valid`, `out_last`, `busy`, `core_en` = 0; `out_data`, `core_data_in`, `core_key_in` = 0; FIFO empty; counter and chain = 0.
- `cfg_load` in cycle t gives `busy` = 1 and `in_ready` possibly 1 at t+1.
- Input accepted at t gives `core_en` = 1 from t+1.
- `core_data_out_valid` at cycle c gives `out_valid` = 1 at c+1 (if the FIFO was empty) and `core_en` = 0 at c+1.
- Earliest next input acceptance is c+2, so throughput is one block per (core latency + 3) cycles.
- `in_ready` and `out_valid` are registered and carry no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `aes_pkg`:
  - `aes_block_t` (logic [127:0]).
  - Mode enum `aes_mode_e` with `MODE_ECB` = 0, `MODE_CBC` = 1, `MODE_CTR` = 2.
  - State enum.
- Sub-module `aes_out_fifo`: synchronous FIFO parametrised by `OUT_DEPTH`, 129 bits wide (data + last), with count output, async active-low reset, and synchronous flush.
- `AES_top` is instantiated by the parent, not inside this block.

## Test plan
All scenarios use a behavioural `AES_top` model with 10-cycle latency.
- ECB, FIPS-197 C.1: key `000102030405060708090a0b0c0d0e0f`, pt `00112233445566778899aabbccddeeff` with `in_last` = 1 → `out_data` = `69c4e0d86a7b0430d8cdb78070b4c55a`, `out_last` = 1, then `busy` falls.
- CBC, SP800-38A F.2.1: key `2b7e151628aed2a6abf7158809cf4f3c`, IV `000102…0f`, blocks 1–2 → `7649abac8119b246cee98e9b12e9197d`, then `5086cb9b507219ee95db113a917678b2`.
- CTR, SP800-38A F.5.1: IV `f0f1…feff`, pt1 `6bc1bee22e409f96e93d7e117393172a` → `874d6191b620e3261bef6864990db6ce`. The second core input must equal `f0f1…fdff00`.
- CTR wrap with `CTR_W` = 32: IV `…_ffffffff` → second core input `…_00000000` with the upper 96 bits unchanged.
- Backpressure: hold `out_ready` = 0 and feed 6 blocks → exactly 4 accepted, `in_ready` = 0 with FIFO full. Release → outputs arrive in order and the remaining 2 blocks complete.
- Abort: assert `abort` while in `RUN` with 2 entries queued → next cycle `out_valid` = 0, `core_en` = 0, `busy` = 0. A following `cfg_load` plus ECB vector gives the correct result.
